// File: rtl/mano_output_port.sv
// Mano machine output port: OUTR, FGO flag and an 8N1-style serialiser.
// Optional even parity bit when MANO_OUTPUT_PARITY_EN is defined.
module mano_output_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] ac_in,
  input  logic       out_load_in,
  output logic [7:0] outr_out,
  output logic       fgo_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
  localparam logic SMAX = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MANO_OUTPUT_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    outr_q, outr_d;
  logic          tx_q, tx_d;
  logic          wrap;

  assign wrap = (baud_q == BMAX);

  always_comb begin
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    outr_d  = outr_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (out_load_in) begin
          outr_d  = ac_in;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = outr_q[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
`ifdef MANO_OUTPUT_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^outr_q;
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = outr_q[bit_q + 3'd1];
          end
        end
      end
`ifdef MANO_OUTPUT_PARITY_EN
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (wrap) begin
          if (stop_q == SMAX) begin
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      outr_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      outr_q  <= outr_d;
      tx_q    <= tx_d;
    end
  end

  // FGO is exactly "sitting in IDLE"; the frame end edge is the IDLE entry.
  assign fgo_out  = (state_q == S_IDLE);
  assign busy_out = ~fgo_out;
  assign outr_out = outr_q;
  assign tx_out   = tx_q;

endmodule

// File: tb/tb_mano_output_port.sv
// Directed bench for mano_output_port at CLKS_PER_BIT=4, STOP_BITS=1.
module tb_mano_output_port;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef MANO_OUTPUT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR + SB - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ac = 8'h00;
  logic       load = 1'b0;
  logic [7:0] outr;
  logic       fgo, tx, busy;

  int tests = 0;
  int fails = 0;

  mano_output_port #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk_in      (clk),
    .reset_in    (reset),
    .ac_in       (ac),
    .out_load_in (load),
    .outr_out    (outr),
    .fgo_out     (fgo),
    .tx_out      (tx),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (PAR == 1 && n == 9) return ^b;
    return 1'b1;
  endfunction

  // Load byte b from IDLE and check every cycle of the frame.
  task automatic frame(input logic [7:0] b, input bit strobes);
    ac   = b;
    load = 1'b1;
    tick();
    load = 1'b0;
    ac   = 8'h00;
    chk("outr_load", outr, b);
    chk("fgo_load", {7'd0, fgo}, 8'd0);
    for (int i = 0; i < NBITS * CPB; i++) begin
      chk($sformatf("tx_%0d", i), {7'd0, tx}, {7'd0, exp_tx(b, i / CPB)});
      chk($sformatf("busy_%0d", i), {7'd0, busy}, 8'd1);
      if (strobes && (i == 12 || i == NBITS * CPB - 1)) begin
        ac   = 8'h3C;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
      ac   = 8'h00;
    end
    chk("fgo_end", {7'd0, fgo}, 8'd1);
    chk("busy_end", {7'd0, busy}, 8'd0);
    chk("tx_end", {7'd0, tx}, 8'd1);
    chk("outr_hold", outr, b);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("rst_outr", outr, 8'h00);
    chk("rst_fgo", {7'd0, fgo}, 8'd1);
    chk("rst_tx", {7'd0, tx}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    reset = 1'b0;
    tick();
    chk("idle_tx", {7'd0, tx}, 8'd1);

    frame(8'hA5, 1'b1);
    tick();
    chk("busy_ign_fgo", {7'd0, fgo}, 8'd1);
    chk("busy_ign_tx", {7'd0, tx}, 8'd1);
    chk("busy_ign_outr", outr, 8'hA5);

    frame(8'h01, 1'b0);
    frame(8'h80, 1'b0);
    tick();
    chk("b2b_idle", {7'd0, fgo}, 8'd1);

    ac   = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) tick();
    chk("mid_tx", {7'd0, tx}, 8'd1);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_tx", {7'd0, tx}, 8'd1);
    chk("abort_fgo", {7'd0, fgo}, 8'd1);
    chk("abort_outr", outr, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    frame(8'h55, 1'b0);

    frame(8'h07, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mano_output_port.md
Name: mano_output_port

Overview:
- Output side of the Mano machine I/O pair; the ALU consumes INPR, and this block produces the outgoing character.
- Holds OUTR, which the OUT instruction loads from AC[7:0].
- Maintains the FGO ready flag used by SKO and by the interrupt logic.
- Serialises OUTR onto an asynchronous 8N1-style line. FGO rises again when the frame has fully left the pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 1
STOP_BITS, 1, number of stop bits per frame; 1 or 2

Ports:
clk_in  input  1  system clock; all state changes on rising edge
reset_in  input  1  synchronous, active-high reset
ac_in  input  8  AC[7:0], the byte to be sent
out_load_in  input  1  OUT instruction strobe: load OUTR, clear FGO, start frame
outr_out  output  8  current OUTR contents
fgo_out  output  1  output flag; 1 = ready for a new character
tx_out  output  1  serial line; idle high
busy_out  output  1  1 while a frame is in progress; equals ~fgo_out

Behaviour:
- Reset values, checked at any edge with reset_in=1: outr_out=8'h00, fgo_out=1, tx_out=1, busy_out=0, state=IDLE, bit and baud counters 0. Reset has priority over every other input.
- Reset mid-frame: the frame is aborted. After that edge tx_out=1 immediately, with no partial stop bit.
- States: IDLE, START, DATA, [PARITY], STOP.
- Load acceptance:
  - A load is accepted only when out_load_in=1 at an edge where state=IDLE (fgo_out=1).
  - At that edge: outr_out<=ac_in, fgo_out<=0, state<=START, tx_out<=0.
  - The start bit is therefore visible on the cycle after the strobe.
- Busy loads: out_load_in while fgo_out=0 is ignored. OUTR, the frame and the counters are unaffected; software must poll FGO via SKO.
- Bit timing:
  - Every bit, including start, each data bit, parity and each stop bit, holds tx_out for exactly CLKS_PER_BIT cycles.
  - A baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- START: tx_out=0. After one bit time, go to DATA.
- DATA:
  - Bits are sent LSB first, tx_out=outr_out[i] for i=0..7.
  - A 3-bit index wraps after bit 7 to PARITY when enabled, otherwise to STOP.
- STOP: tx_out=1 for STOP_BITS bit times.
- Frame end:
  - At the edge ending the last stop bit: state<=IDLE, fgo_out<=1.
  - fgo_out is therefore 0 for exactly (10+STOP_BITS-1)*CLKS_PER_BIT cycles after the load edge (+CLKS_PER_BIT with parity). That is 10*CLKS_PER_BIT for STOP_BITS=1 without parity.
- Load in the final stop-bit cycle: at that edge state is still STOP, so the load is ignored. A new load is accepted no earlier than the cycle in which fgo_out reads 1.
- Back-to-back loads: a load in the first IDLE cycle starts the next frame with no extra idle bit time.
- OUTR persistence: outr_out holds the last accepted byte after the frame until the next accepted load. It is not cleared by frame completion.
- CLKS_PER_BIT=1: one cycle per bit, with the same sequencing.

Optional Feature:
- Macro: MANO_OUTPUT_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and lasts one bit time.
  - tx_out=^outr_out (even parity).
  - Frame length grows by CLKS_PER_BIT and fgo_out low time grows accordingly.
- Undefined: the PARITY state and its logic do not exist; DATA goes directly to STOP.

Test Plan:
- Reset: hold reset_in=1 two cycles -> outr_out=00, fgo_out=1, tx_out=1, busy_out=0.
- Single frame (CLKS_PER_BIT=4, STOP_BITS=1), ac_in=8'hA5 with out_load_in pulsed one cycle:
  - outr_out=A5 and fgo_out=0 after the edge.
  - tx_out sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - fgo_out returns to 1 exactly 40 cycles after the load edge.
- Busy load: during that frame, strobe with ac_in=8'h3C at cycle 12 and in the last stop cycle -> both ignored; outr_out stays A5 and the tx_out pattern is unchanged.
- Back-to-back: load 8'h01, then load 8'h80 on the first cycle fgo_out=1 -> the second start bit immediately follows the first stop bit; both frames are correct.
- Reset mid-frame: reset_in during data bit 3 of 8'hFF -> tx_out=1, fgo_out=1, outr_out=00 next cycle; a subsequent load of 8'h55 sends a clean frame.
- With MANO_OUTPUT_PARITY_EN, load 8'h07 -> parity bit 1 after bit 7; fgo_out low for 44 cycles at CLKS_PER_BIT=4.
